// File: rtl/imm_extender_pipe.sv
// Registered immediate extender (zero / sign / upper placement) with a
// valid/ready handshake and an output register backed by one skid entry.
module imm_extender_pipe #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             err,
    input  logic             err_clr
);

    localparam int PAD = OUT_W - IN_W;

    // Occupancy: EMPTY = nothing held, ONE = OREG only, FULL = OREG + SKID.
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   oreg_q, oreg_d;
    logic [OUT_W-1:0]   skid_q, skid_d;
    logic               err_q, err_d;
    logic [OUT_W-1:0]   ext;
    logic               acc, drain;

    assign acc   = in_valid & in_ready;
    assign drain = out_valid & out_ready;

    // Illegal mode falls through to zero extension.
    always_comb begin
        ext = {{PAD{1'b0}}, in_imm};
        case (in_mode)
            2'b01:   ext = {{PAD{in_imm[IN_W-1]}}, in_imm};
            2'b10:   ext = {in_imm, {PAD{1'b0}}};
            default: ext = {{PAD{1'b0}}, in_imm};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            oreg_q  <= '0;
            skid_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            oreg_q  <= oreg_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (acc) state_d = ONE;
            ONE: begin
                if (acc && !drain)      state_d = FULL;
                else if (!acc && drain) state_d = EMPTY;
            end
            FULL:    if (drain) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // SKID only fills while OREG is stuck; in FULL in_ready is low, so a
    // SKID->OREG move never coincides with an accept.
    always_comb begin
        oreg_d = oreg_q;
        skid_d = skid_q;
        if (!out_valid || drain) begin
            if (state_q == FULL) oreg_d = skid_q;
            else if (acc)        oreg_d = ext;
        end else if (acc) begin
            skid_d = ext;
        end
    end

    // Set wins over clear.
    assign err_d = (err_q & ~err_clr) | (acc & (in_mode == 2'b11));

    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        out_data  = oreg_q;
        err       = err_q;
    end

endmodule
